// File: rtl/msg_stream_arbiter.sv
// msg_stream_arbiter
// Packet-level round-robin arbiter. One upstream port at a time is locked
// from sop to eop and its beats pass combinationally to the single
// downstream interface. Mid-packet beats from ports that do not own the
// lock are accepted and thrown away. Those drop cycles are counted in a
// saturating counter.
module msg_stream_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH / 8),
  parameter int PORT_W      = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             in_valid,
  input  logic [NUM_PORTS-1:0]             in_startofpacket,
  input  logic [NUM_PORTS-1:0]             in_endofpacket,
  input  logic [NUM_PORTS-1:0]             in_error,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS*EMPTY_WIDTH-1:0] in_empty,
  output logic [NUM_PORTS-1:0]             in_ready,
  output logic                             out_valid,
  output logic                             out_startofpacket,
  output logic                             out_endofpacket,
  output logic                             out_error,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [EMPTY_WIDTH-1:0]           out_empty,
  input  logic                             out_ready,
  output logic [PORT_W-1:0]                out_port,
  output logic [15:0]                      drop_count
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]           state;
  logic [PORT_W-1:0]    grant;
  logic [PORT_W-1:0]    rr_ptr;

  logic                 locked;
  logic                 active;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] stray;
  logic [NUM_PORTS-1:0] own;
  logic                 found;
  logic [PORT_W-1:0]    pick;
  logic [PORT_W:0]      idx_w;
  logic                 eop_xfer;
  logic [PORT_W-1:0]    next_rr;

  assign locked = (state == LOCKED);
  // Outputs are forced quiet while reset is held, even if the state is stale.
  assign active = reset_n && locked;

  // Classify every port each cycle as owner, requester or stray source.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise synthesis infers a latch to hold the old value.
    own      = '0;
    req      = '0;
    stray    = '0;
    in_ready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      own[p]      = locked && (grant == PORT_W'(p));
      req[p]      = in_valid[p] && in_startofpacket[p];
      stray[p]    = in_valid[p] && !in_startofpacket[p] && !own[p];
      in_ready[p] = reset_n && (stray[p] || (own[p] && out_ready));
    end
  end

  // Round-robin search for the first requester starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx_w = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx_w = {1'b0, rr_ptr} + (PORT_W + 1)'(i);
      if (idx_w >= (PORT_W + 1)'(NUM_PORTS)) begin
        idx_w = idx_w - (PORT_W + 1)'(NUM_PORTS);
      end
      if (!found && req[idx_w[PORT_W-1:0]]) begin
        found = 1'b1;
        pick  = idx_w[PORT_W-1:0];
      end
    end
  end

  // Zero-latency pass-through of the locked port to the downstream side.
  always_comb begin
    out_valid         = active && in_valid[grant];
    out_startofpacket = active && in_startofpacket[grant];
    out_endofpacket   = active && in_endofpacket[grant];
    out_error         = active && in_error[grant];
    out_data          = in_data[grant*DATA_WIDTH +: DATA_WIDTH];
    out_empty         = in_empty[grant*EMPTY_WIDTH +: EMPTY_WIDTH];
    out_port          = grant;
  end

  assign eop_xfer = in_valid[grant] && out_ready && in_endofpacket[grant];
  assign next_rr  = (grant == PORT_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;

  // Arbitration FSM, round-robin pointer and drop counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the reset branch is synchronous (no rst edge
    // in the sensitivity list).
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      drop_count <= '0;
    end else begin
      if (state == IDLE) begin
        if (found) begin
          grant <= pick;
          state <= LOCKED;
        end
      end else if (eop_xfer) begin
        state  <= IDLE;
        rr_ptr <= next_rr;
      end
      if ((|stray) && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Testbench for msg_stream_arbiter. Per-port source queues drive beats
// through the valid/ready handshake; every beat expected downstream is
// pushed to a scoreboard queue when queued and popped as it emerges.
module tb_msg_stream_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int PW = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NP-1:0]    in_valid;
  logic [NP-1:0]    in_startofpacket;
  logic [NP-1:0]    in_endofpacket;
  logic [NP-1:0]    in_error;
  logic [NP*DW-1:0] in_data;
  logic [NP*EW-1:0] in_empty;
  logic [NP-1:0]    in_ready;
  logic             out_valid;
  logic             out_startofpacket;
  logic             out_endofpacket;
  logic             out_error;
  logic [DW-1:0]    out_data;
  logic [EW-1:0]    out_empty;
  logic             out_ready;
  logic [PW-1:0]    out_port;
  logic [15:0]      drop_count;

  msg_stream_arbiter #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_error          (in_error),
    .in_data           (in_data),
    .in_empty          (in_empty),
    .in_ready          (in_ready),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_error         (out_error),
    .out_data          (out_data),
    .out_empty         (out_empty),
    .out_ready         (out_ready),
    .out_port          (out_port),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic          err;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [PW-1:0] port;
    beat_t         beat;
  } exp_t;

  beat_t src_q [NP][$];
  exp_t  exp_q [$];

  int total = 0;
  int bad   = 0;
  int seq   = 0;

  logic [NP-1:0] rdy_s;
  logic [NP-1:0] xfer;
  logic          ov_s;
  logic          sop_s;
  logic          eop_s;
  logic [PW-1:0] op_s;
  logic [EW-1:0] emp_s;

  // Queue a packet on a port; optionally record it as expected downstream.
  task automatic send_pkt(input int port, input int nbeats, input int empty_last,
                          input bit expect_out);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < nbeats; i++) begin
      b.sop   = (i == 0);
      b.eop   = (i == nbeats - 1);
      b.err   = (i == 1);
      b.empty = (i == nbeats - 1) ? EW'(empty_last) : '0;
      b.data  = {16'hC0DE, 16'(port), 32'(seq)};
      seq++;
      src_q[port].push_back(b);
      if (expect_out) begin
        e.port = PW'(port);
        e.beat = b;
        exp_q.push_back(e);
      end
    end
  endtask

  // Queue mid-packet beats (sop=0) that must be discarded.
  task automatic send_stray(input int port, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.sop   = 1'b0;
      b.eop   = 1'b0;
      b.err   = 1'b0;
      b.empty = '0;
      b.data  = {16'hBAD0, 16'(port), 32'(seq)};
      seq++;
      src_q[port].push_back(b);
    end
  endtask

  // One clock: present queue heads, sample at negedge, score output, pop.
  task automatic tick();
    beat_t hb;
    exp_t  got;
    exp_t  want;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        hb = src_q[p][0];
        in_valid[p]          = 1'b1;
        in_startofpacket[p]  = hb.sop;
        in_endofpacket[p]    = hb.eop;
        in_error[p]          = hb.err;
        in_data[p*DW +: DW]  = hb.data;
        in_empty[p*EW +: EW] = hb.empty;
      end else begin
        in_valid[p]          = 1'b0;
        in_startofpacket[p]  = 1'b0;
        in_endofpacket[p]    = 1'b0;
        in_error[p]          = 1'b0;
      end
    end
    @(negedge clk);
    rdy_s = in_ready;
    ov_s  = out_valid;
    op_s  = out_port;
    sop_s = out_startofpacket;
    eop_s = out_endofpacket;
    emp_s = out_empty;
    xfer  = in_valid & in_ready;
    if (out_valid && out_ready) begin
      got.port = out_port;
      got.beat = {out_startofpacket, out_endofpacket, out_error, out_empty, out_data};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_unexpected: got %h, expected no beat", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL scoreboard_beat: got %h, expected %h", got, want);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (xfer[p]) void'(src_q[p].pop_front());
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    out_ready = 1'b1;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s: %0d expected beats never emerged, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n          = 1'b0;
    out_ready        = 1'b1;
    in_valid         = '1;
    in_startofpacket = 4'b0101;
    in_endofpacket   = '1;
    in_error         = '1;
    in_data          = '0;
    in_empty         = '0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, out_startofpacket, out_endofpacket, out_error} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_out_flags: got %b, required 0000",
               {out_valid, out_startofpacket, out_endofpacket, out_error});
    end
    total++;
    if (in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_in_ready: got %b, required 0000", in_ready);
    end
    total++;
    if (drop_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_drop_count: got %0d, required 0", drop_count);
    end
    @(posedge clk);
    #1;
    in_valid = '0;
    reset_n  = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || drop_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_release: out_valid=%b drop_count=%0d, required 0/0", out_valid, drop_count);
    end
  endtask

  task automatic test_single_port();
    do_reset();
    send_pkt(1, 3, 0, 1'b1);
    tick();
    total++;
    if (ov_s !== 1'b0 || rdy_s !== 4'b0000) begin
      bad++;
      $display("FAIL sp_arb_cycle: out_valid=%b in_ready=%b, required 0/0000", ov_s, rdy_s);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ov_s !== 1'b1 || op_s !== 2'd1 || rdy_s !== 4'b0010) begin
        bad++;
        $display("FAIL sp_beat%0d: valid=%b port=%0d in_ready=%b, required 1/1/0010",
                 i, ov_s, op_s, rdy_s);
      end
    end
    tick();
    total++;
    if (ov_s !== 1'b0) begin
      bad++;
      $display("FAIL sp_idle_after_eop: out_valid=%b, required 0", ov_s);
    end
    // rr_ptr is now 2: with ports 1 and 3 requesting together, 3 wins.
    send_pkt(3, 1, 0, 1'b1);
    send_pkt(1, 1, 0, 1'b1);
    tick();
    tick();
    total++;
    if (ov_s !== 1'b1 || op_s !== 2'd3) begin
      bad++;
      $display("FAIL sp_rr_from_2: valid=%b port=%0d, required 1/3", ov_s, op_s);
    end
    tick();
    tick();
    total++;
    if (ov_s !== 1'b1 || op_s !== 2'd1) begin
      bad++;
      $display("FAIL sp_rr_wrap: valid=%b port=%0d, required 1/1", ov_s, op_s);
    end
    tick();
    check_drained("sp_drained");
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int p = 0; p < NP; p++) send_pkt(p, 2, 0, 1'b1);
    send_pkt(0, 2, 0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      g = k % NP;
      tick();
      total++;
      if (ov_s !== 1'b0 || rdy_s !== 4'b0000) begin
        bad++;
        $display("FAIL rr_idle%0d: valid=%b in_ready=%b, required 0/0000", k, ov_s, rdy_s);
      end
      for (int b = 0; b < 2; b++) begin
        tick();
        total++;
        if (ov_s !== 1'b1 || op_s !== PW'(g) || rdy_s !== (4'b0001 << g)) begin
          bad++;
          $display("FAIL rr_pkt%0d_beat%0d: valid=%b port=%0d in_ready=%b, required port %0d one-hot",
                   k, b, ov_s, op_s, rdy_s, g);
        end
      end
    end
    tick();
    check_drained("rr_drained");
  endtask

  task automatic test_backpressure();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    send_pkt(2, 4, 5, 1'b1);
    tick();
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      tick();
      total++;
      if (rdy_s[2] !== pat[i] || ov_s !== 1'b1 || op_s !== 2'd2) begin
        bad++;
        $display("FAIL bp_cycle%0d: in_ready2=%b valid=%b port=%0d, required %b/1/2",
                 i, rdy_s[2], ov_s, op_s, pat[i]);
      end
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (ov_s !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b, required 0", ov_s);
    end
    check_drained("bp_four_transfers");
  endtask

  task automatic test_stray_drop();
    do_reset();
    send_pkt(0, 6, 0, 1'b1);
    tick();
    send_stray(3, 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (rdy_s[3] !== 1'b1 || op_s !== 2'd0 || ov_s !== 1'b1) begin
        bad++;
        $display("FAIL stray_cycle%0d: in_ready3=%b port=%0d valid=%b, required 1/0/1",
                 i, rdy_s[3], op_s, ov_s);
      end
    end
    tick();
    tick();
    total++;
    if (drop_count !== 16'd5) begin
      bad++;
      $display("FAIL stray_drop_count: got %0d, required 5", drop_count);
    end
    check_drained("stray_drained");
  endtask

  task automatic test_single_beat();
    do_reset();
    send_pkt(0, 1, 3, 1'b1);
    tick();
    send_pkt(1, 2, 0, 1'b1);
    tick();
    total++;
    if (ov_s !== 1'b1 || sop_s !== 1'b1 || eop_s !== 1'b1 || emp_s !== 3'd3 || rdy_s[1] !== 1'b0) begin
      bad++;
      $display("FAIL sb_beat: valid=%b sop=%b eop=%b empty=%0d in_ready1=%b, required 1/1/1/3/0",
               ov_s, sop_s, eop_s, emp_s, rdy_s[1]);
    end
    tick();
    total++;
    if (ov_s !== 1'b0) begin
      bad++;
      $display("FAIL sb_idle_gap: out_valid=%b, required 0", ov_s);
    end
    tick();
    total++;
    if (ov_s !== 1'b1 || op_s !== 2'd1) begin
      bad++;
      $display("FAIL sb_next_grant: valid=%b port=%0d, required 1/1", ov_s, op_s);
    end
    tick();
    tick();
    check_drained("sb_drained");
  endtask

  task automatic test_reset_mid_packet();
    exp_t e;
    do_reset();
    send_pkt(1, 4, 0, 1'b0);
    // Only the first beat gets out before reset abandons the packet.
    e.port = 2'd1;
    e.beat = src_q[1][0];
    exp_q.push_back(e);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    total++;
    if (ov_s !== 1'b0 || rdy_s !== 4'b0000) begin
      bad++;
      $display("FAIL rst_mid_during: valid=%b in_ready=%b, required 0/0000", ov_s, rdy_s);
    end
    void'(src_q[1].pop_front());
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (ov_s !== 1'b0 || rdy_s[1] !== 1'b1) begin
        bad++;
        $display("FAIL rst_mid_drop%0d: valid=%b in_ready1=%b, required 0/1", i, ov_s, rdy_s[1]);
      end
    end
    tick();
    total++;
    if (drop_count !== 16'd2 || ov_s !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_count: drop_count=%0d valid=%b, required 2/0", drop_count, ov_s);
    end
    check_drained("rst_mid_drained");
  endtask

  initial begin
    reset_n          = 1'b0;
    out_ready        = 1'b1;
    in_valid         = '0;
    in_startofpacket = '0;
    in_endofpacket   = '0;
    in_error         = '0;
    in_data          = '0;
    in_empty         = '0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_stray_drop();
    test_single_beat();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
